// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the multi-approach traffic-light controller:
//   - phase_t        : controller state encoding (ALLRED, GREEN, YELLOW, FLASH)
//   - DEF_*          : default phase durations and approach count
//   - timer_width()  : width of a down-counter able to hold the longest phase
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } phase_t;

    localparam int DEF_NUM_DIR       = 2;
    localparam int DEF_GREEN_CYCLES  = 8;
    localparam int DEF_YELLOW_CYCLES = 3;
    localparam int DEF_ALLRED_CYCLES = 2;
    localparam int DEF_FLASH_HALF    = 4;

    // Timer is loaded with (duration - 1), so $clog2 of the longest duration
    // is enough; never let it collapse to zero bits when every duration is 1.
    function automatic int timer_width(input int a, input int b,
                                       input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches approaches starting just after
// the current one and wrapping, so the current approach is considered last.
// Ports:
//   i_req      [NUM_DIR-1:0]  per-approach demand
//   i_cur_dir  [DW-1:0]       approach currently / last served
//   o_next     [DW-1:0]       first requesting approach in round-robin order
//   o_valid                   at least one approach is requesting
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_DIR = 2,
    parameter int DW      = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] i_req,
    input  logic [DW-1:0]      i_cur_dir,
    output logic [DW-1:0]      o_next,
    output logic               o_valid
);

    localparam int SW = DW + 1;

    logic [SW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest; the nearest requester
    // is written last and therefore wins.
    always_comb begin
        o_next  = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            w_idx = {1'b0, i_cur_dir} + SW'(k);
            if (w_idx >= SW'(NUM_DIR)) begin
                w_idx = w_idx - SW'(NUM_DIR);
            end else begin
                w_idx = w_idx;
            end
            if (i_req[w_idx[DW-1:0]]) begin
                o_next  = w_idx[DW-1:0];
                o_valid = 1'b1;
            end else begin
                o_next  = o_next;
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Multi-approach traffic-light controller. Serves NUM_DIR approaches in
// round-robin order (GREEN -> YELLOW -> ALLRED), skipping approaches without
// demand, with a flashing-yellow override.
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   req     [NUM_DIR-1:0]    per-approach demand (level)
//   flash                    flashing-yellow request (level)
//   red     [NUM_DIR-1:0]    red lamps     (registered)
//   yellow  [NUM_DIR-1:0]    yellow lamps  (registered)
//   green   [NUM_DIR-1:0]    green lamps   (registered)
//   cur_dir [DW-1:0]         approach currently or last served (registered)
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR       = DEF_NUM_DIR,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
    parameter int FLASH_HALF    = DEF_FLASH_HALF,
    parameter int DW            = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DIR-1:0] req,
    input  logic               flash,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DW-1:0]      cur_dir
);

    localparam int TW = timer_width(GREEN_CYCLES, YELLOW_CYCLES,
                                    ALLRED_CYCLES, FLASH_HALF);

    localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_CYCLES  - 1);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_CYCLES - 1);
    localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_HALF    - 1);

    phase_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [DW-1:0]       r_dir;
    logic                r_phase;
    logic [NUM_DIR-1:0]  r_red;
    logic [NUM_DIR-1:0]  r_yellow;
    logic [NUM_DIR-1:0]  r_green;

    phase_t              w_state_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [DW-1:0]       w_dir_nxt;
    logic                w_phase_nxt;
    logic [NUM_DIR-1:0]  w_red_nxt;
    logic [NUM_DIR-1:0]  w_yellow_nxt;
    logic [NUM_DIR-1:0]  w_green_nxt;
    logic [NUM_DIR-1:0]  w_onehot;
    logic [DW-1:0]       w_pick;
    logic                w_pick_valid;
    logic                w_expired;

    rr_pick #(
        .NUM_DIR (NUM_DIR),
        .DW      (DW)
    ) u_rr_pick (
        .i_req     (req),
        .i_cur_dir (r_dir),
        .o_next    (w_pick),
        .o_valid   (w_pick_valid)
    );

    assign w_expired = (r_timer == '0);

    // State, timer, served approach and flash phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ALLRED;
            r_timer <= T_ALLRED;
            r_dir   <= DW'(NUM_DIR - 1);
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_dir   <= w_dir_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next-state logic; flash overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_expired ? r_timer : (r_timer - TW'(1));
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        if (flash) begin
            w_state_nxt = ST_FLASH;
            if (r_state != ST_FLASH) begin
                w_timer_nxt = T_FLASH;
                w_phase_nxt = 1'b1;
            end else if (w_expired) begin
                w_timer_nxt = T_FLASH;
                w_phase_nxt = ~r_phase;
            end else begin
                w_phase_nxt = r_phase;
            end
        end else begin
            case (r_state)
                ST_ALLRED: begin
                    // With no demand the timer simply parks at zero.
                    if (w_expired && w_pick_valid) begin
                        w_state_nxt = ST_GREEN;
                        w_timer_nxt = T_GREEN;
                        w_dir_nxt   = w_pick;
                    end else begin
                        w_state_nxt = ST_ALLRED;
                    end
                end
                ST_GREEN: begin
                    if (w_expired) begin
                        w_state_nxt = ST_YELLOW;
                        w_timer_nxt = T_YELLOW;
                    end else begin
                        w_state_nxt = ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (w_expired) begin
                        w_state_nxt = ST_ALLRED;
                        w_timer_nxt = T_ALLRED;
                    end else begin
                        w_state_nxt = ST_YELLOW;
                    end
                end
                ST_FLASH: begin
                    // cur_dir is kept, so the interrupted approach goes last.
                    w_state_nxt = ST_ALLRED;
                    w_timer_nxt = T_ALLRED;
                end
                default: begin
                    w_state_nxt = ST_ALLRED;
                    w_timer_nxt = T_ALLRED;
                end
            endcase
        end
    end

    // Lamp pattern for the upcoming state, so the lamp registers track it.
    always_comb begin
        w_onehot     = {{(NUM_DIR-1){1'b0}}, 1'b1} << w_dir_nxt;
        w_red_nxt    = {NUM_DIR{1'b1}};
        w_yellow_nxt = {NUM_DIR{1'b0}};
        w_green_nxt  = {NUM_DIR{1'b0}};
        case (w_state_nxt)
            ST_ALLRED: begin
                w_red_nxt = {NUM_DIR{1'b1}};
            end
            ST_GREEN: begin
                w_red_nxt   = ~w_onehot;
                w_green_nxt = w_onehot;
            end
            ST_YELLOW: begin
                w_red_nxt    = ~w_onehot;
                w_yellow_nxt = w_onehot;
            end
            ST_FLASH: begin
                w_red_nxt    = {NUM_DIR{1'b0}};
                w_yellow_nxt = {NUM_DIR{w_phase_nxt}};
            end
            default: begin
                w_red_nxt = {NUM_DIR{1'b1}};
            end
        endcase
    end

    // Lamp output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red    <= {NUM_DIR{1'b1}};
            r_yellow <= {NUM_DIR{1'b0}};
            r_green  <= {NUM_DIR{1'b0}};
        end else begin
            r_red    <= w_red_nxt;
            r_yellow <= w_yellow_nxt;
            r_green  <= w_green_nxt;
        end
    end

    assign red     = r_red;
    assign yellow  = r_yellow;
    assign green   = r_green;
    assign cur_dir = r_dir;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_ctrl
// Two controllers: A with two approaches, B with four. Stimulus pushes the
// hand-computed lamp state expected after each clock edge into a per-DUT
// queue; a monitor pops and compares one entry per edge.
// -----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] y;
        logic [1:0] g;
        logic [0:0] d;
    } exp2_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [1:0] d;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_a;
    logic       flash_a;
    logic [1:0] red_a, yellow_a, green_a;
    logic [0:0] dir_a;
    logic [3:0] req_b;
    logic       flash_b;
    logic [3:0] red_b, yellow_b, green_b;
    logic [1:0] dir_b;

    exp2_t q2[$];
    exp4_t q4[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl dut_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .flash   (flash_a),
        .red     (red_a),
        .yellow  (yellow_a),
        .green   (green_a),
        .cur_dir (dir_a)
    );

    traffic_phase_ctrl #(.NUM_DIR(4)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .flash   (flash_b),
        .red     (red_b),
        .yellow  (yellow_b),
        .green   (green_b),
        .cur_dir (dir_b)
    );

    // Entered at a negedge; drives inputs and expects the state after the
    // following posedge, once per cycle, ending at a negedge.
    task automatic cyc2(input int n, input logic [1:0] rq, input logic fl,
                        input logic [1:0] r, input logic [1:0] y,
                        input logic [1:0] g, input logic [0:0] d);
        exp2_t e;
        e = '{r: r, y: y, g: g, d: d};
        for (int i = 0; i < n; i++) begin
            req_a   = rq;
            flash_a = fl;
            q2.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic cyc4(input int n, input logic [3:0] rq,
                        input logic [3:0] r, input logic [3:0] y,
                        input logic [3:0] g, input logic [1:0] d);
        exp4_t e;
        e = '{r: r, y: y, g: g, d: d};
        for (int i = 0; i < n; i++) begin
            req_b   = rq;
            flash_b = 1'b0;
            q4.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_a(input string tag);
        checks++;
        if ({red_a, yellow_a, green_a, dir_a} !== {2'b11, 2'b00, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL %s: got r=%b y=%b g=%b dir=%b, want r=11 y=00 g=00 dir=1",
                     tag, red_a, yellow_a, green_a, dir_a);
        end
    endtask

    // Monitor: one scoreboard entry per edge, sampled just after the edge.
    initial begin
        exp2_t e2;
        exp4_t e4;
        forever begin
            @(posedge clk);
            #1;
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                checks++;
                if ({red_a, yellow_a, green_a, dir_a} !== e2) begin
                    errors++;
                    $display("FAIL dutA t=%0t: got r=%b y=%b g=%b dir=%b, want r=%b y=%b g=%b dir=%b",
                             $time, red_a, yellow_a, green_a, dir_a, e2.r, e2.y, e2.g, e2.d);
                end
            end
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                checks++;
                if ({red_b, yellow_b, green_b, dir_b} !== e4) begin
                    errors++;
                    $display("FAIL dutB t=%0t: got r=%b y=%b g=%b dir=%0d, want r=%b y=%b g=%b dir=%0d",
                             $time, red_b, yellow_b, green_b, dir_b, e4.r, e4.y, e4.g, e4.d);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req_a   = 2'b00;
        flash_a = 1'b0;
        req_b   = 4'b0000;
        flash_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_a("reset_values");
        rst = 1'b0;

        // Full rotation with both approaches requesting.
        cyc2(1, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1);
        cyc2(8, 2'b11, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);
        cyc2(3, 2'b11, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0);
        cyc2(2, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        cyc2(8, 2'b11, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1);
        cyc2(3, 2'b11, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1);
        cyc2(2, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1);
        cyc2(4, 2'b11, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);

        // Asynchronous reset mid-GREEN.
        #2 rst = 1'b1;
        #1 check_reset_a("async_reset_mid_green");
        @(negedge clk);
        rst = 1'b0;
        cyc2(1, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1);

        // Flash raised during the 4th GREEN cycle.
        cyc2(4, 2'b11, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);
        cyc2(4, 2'b11, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0);
        cyc2(4, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc2(2, 2'b11, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0);
        // Flash dropped: full all-red, then approach 1 (after the interrupted 0).
        cyc2(2, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        cyc2(8, 2'b11, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1);

        // Single requester: approach 0 re-served, approach 1 stays red.
        cyc2(3, 2'b01, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1);
        cyc2(2, 2'b01, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1);
        cyc2(8, 2'b01, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);
        cyc2(3, 2'b01, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0);
        cyc2(2, 2'b01, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        cyc2(8, 2'b01, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);
        // Demand removed: finish service, then hold all-red.
        cyc2(3, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0);
        cyc2(6, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);

        // Four approaches: idle since reset, all-red held.
        cyc4(5, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd3);
        // One-cycle pulse on req[2] -> green on the next edge.
        cyc4(1, 4'b0100, 4'b1011, 4'b0000, 4'b0100, 2'd2);
        cyc4(7, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 2'd2);
        cyc4(3, 4'b0000, 4'b1011, 4'b0100, 4'b0000, 2'd2);
        cyc4(4, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd2);
        // Skip: only approaches 1 and 3 requesting -> 3, 1, 3, 1.
        cyc4(8, 4'b1010, 4'b0111, 4'b0000, 4'b1000, 2'd3);
        cyc4(3, 4'b1010, 4'b0111, 4'b1000, 4'b0000, 2'd3);
        cyc4(2, 4'b1010, 4'b1111, 4'b0000, 4'b0000, 2'd3);
        cyc4(8, 4'b1010, 4'b1101, 4'b0000, 4'b0010, 2'd1);
        cyc4(3, 4'b1010, 4'b1101, 4'b0010, 4'b0000, 2'd1);
        cyc4(2, 4'b1010, 4'b1111, 4'b0000, 4'b0000, 2'd1);
        cyc4(8, 4'b1010, 4'b0111, 4'b0000, 4'b1000, 2'd3);
        cyc4(3, 4'b1010, 4'b0111, 4'b1000, 4'b0000, 2'd3);
        cyc4(2, 4'b1010, 4'b1111, 4'b0000, 4'b0000, 2'd3);
        cyc4(8, 4'b1010, 4'b1101, 4'b0000, 4'b0010, 2'd1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if ((q2.size() + q4.size()) != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0",
                     q2.size() + q4.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
